// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle controller, the ALU control and the datapath.
package control_pkg;

  // Controller state encoding, also visible on the debug state port.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_ILLEGAL   = 4'd10
  } state_t;

  // Major opcodes understood by the controller; everything else traps.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU operation request handed to the ALU control.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU operand A select.
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_REG    = 2'b01;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

  // ALU operand B select.
  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  // Result bus select.
  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_MEM_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  // Bundle of every control line driven by the controller.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       trap;
    logic       retire;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Where DECODE goes for a given opcode; unknown opcodes end in ILLEGAL.
  function automatic state_t decode_target(input logic [6:0] op);
    state_t target;
    case (op)
      OP_LOAD, OP_STORE: target = S_MEM_ADDR;
      OP_RTYPE:          target = S_EXEC_R;
      OP_ITYPE:          target = S_EXEC_I;
      OP_BRANCH:         target = S_BRANCH;
      default:           target = S_ILLEGAL;
    endcase
    return target;
  endfunction

endpackage

// File: rtl/multi_cycle_control.sv
// Multi-cycle processor main controller: state register, next-state logic and
// output decode. FETCH write enables and the retire pulse depend on memReady
// in the same cycle, so outputs are decoded from the registered state.
module multi_cycle_control
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       memReady,
  output logic       memReq,
  output logic       memWrite,
  output logic       iOrD,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       regWrite,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] resultSrc,
  output logic       trap,
  output logic       retire,
  output logic [3:0] state
);

  state_t state_r;
  state_t next_s;
  ctrl_t  ctrl_s;

  // State register; reset forces FETCH immediately, aborting any instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state selection; memReady only matters in the memory-access states.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (memReady) begin
          next_s = S_DECODE;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_DECODE: next_s = decode_target(opcode);
      S_MEM_ADDR: begin
        if (opcode == OP_LOAD) begin
          next_s = S_MEM_READ;
        end else begin
          next_s = S_MEM_WRITE;
        end
      end
      S_MEM_READ: begin
        if (memReady) begin
          next_s = S_MEM_WB;
        end else begin
          next_s = S_MEM_READ;
        end
      end
      S_MEM_WRITE: begin
        if (memReady) begin
          next_s = S_FETCH;
        end else begin
          next_s = S_MEM_WRITE;
        end
      end
      S_MEM_WB:  next_s = S_FETCH;
      S_EXEC_R:  next_s = S_ALU_WB;
      S_EXEC_I:  next_s = S_ALU_WB;
      S_ALU_WB:  next_s = S_FETCH;
      S_BRANCH:  next_s = S_FETCH;
      S_ILLEGAL: next_s = S_ILLEGAL;
      default:   next_s = S_ILLEGAL;
    endcase
  end

  // Output decode; unlisted controls stay at zero in every state.
  always_comb begin
    ctrl_s = CTRL_IDLE;
    case (state_r)
      S_FETCH: begin
        ctrl_s.mem_req   = 1'b1;
        ctrl_s.alu_src_b = SRC_B_FOUR;
        if (memReady) begin
          ctrl_s.ir_write = 1'b1;
          ctrl_s.pc_write = 1'b1;
        end else begin
          ctrl_s.ir_write = 1'b0;
          ctrl_s.pc_write = 1'b0;
        end
      end
      S_DECODE: begin
        ctrl_s.alu_src_a = SRC_A_OLD_PC;
        ctrl_s.alu_src_b = SRC_B_IMM;
      end
      S_MEM_ADDR: begin
        ctrl_s.alu_src_a = SRC_A_REG;
        ctrl_s.alu_src_b = SRC_B_IMM;
      end
      S_MEM_READ: begin
        ctrl_s.mem_req = 1'b1;
        ctrl_s.i_or_d  = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.result_src = RES_MEM_DATA;
        ctrl_s.retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_s.mem_req   = 1'b1;
        ctrl_s.mem_write = 1'b1;
        ctrl_s.i_or_d    = 1'b1;
        if (memReady) begin
          ctrl_s.retire = 1'b1;
        end else begin
          ctrl_s.retire = 1'b0;
        end
      end
      S_EXEC_R: begin
        ctrl_s.alu_src_a = SRC_A_REG;
        ctrl_s.alu_op    = ALU_OP_FUNCT;
      end
      S_EXEC_I: begin
        ctrl_s.alu_src_a = SRC_A_REG;
        ctrl_s.alu_src_b = SRC_B_IMM;
        ctrl_s.alu_op    = ALU_OP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.retire    = 1'b1;
      end
      S_BRANCH: begin
        ctrl_s.alu_src_a     = SRC_A_REG;
        ctrl_s.alu_op        = ALU_OP_SUB;
        ctrl_s.pc_write_cond = 1'b1;
        ctrl_s.result_src    = RES_ALU_RESULT;
        ctrl_s.retire        = 1'b1;
      end
      S_ILLEGAL: begin
        ctrl_s.trap = 1'b1;
      end
      default: begin
        ctrl_s = CTRL_IDLE;
      end
    endcase
  end

  assign memReq      = ctrl_s.mem_req;
  assign memWrite    = ctrl_s.mem_write;
  assign iOrD        = ctrl_s.i_or_d;
  assign irWrite     = ctrl_s.ir_write;
  assign pcWrite     = ctrl_s.pc_write;
  assign pcWriteCond = ctrl_s.pc_write_cond;
  assign regWrite    = ctrl_s.reg_write;
  assign aluSrcA     = ctrl_s.alu_src_a;
  assign aluSrcB     = ctrl_s.alu_src_b;
  assign aluOp       = ctrl_s.alu_op;
  assign resultSrc   = ctrl_s.result_src;
  assign trap        = ctrl_s.trap;
  assign retire      = ctrl_s.retire;
  assign state       = state_r;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: each instruction is expanded into
// its expected per-cycle phases and latency, and a monitor compares every cycle.
module tb_multi_cycle_control;
  import control_pkg::*;

  localparam int C_LOAD    = 0;
  localparam int C_STORE   = 1;
  localparam int C_RTYPE   = 2;
  localparam int C_ITYPE   = 3;
  localparam int C_BRANCH  = 4;
  localparam int C_ILLEGAL = 5;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic [1:0] res_src;
    logic       trap;
    logic       retire;
  } exp_t;

  typedef struct packed {
    state_t st;
    logic   rdy;
  } step_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       memReady = 1'b0;
  logic       memReq, memWrite, iOrD, irWrite, pcWrite, pcWriteCond, regWrite;
  logic [1:0] aluSrcA, aluSrcB, aluOp, resultSrc;
  logic       trap, retire;
  logic [3:0] state;

  exp_t exp_q[$];
  int   lat_q[$];
  int   errors = 0;
  int   checks = 0;

  multi_cycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
    .memReq(memReq), .memWrite(memWrite), .iOrD(iOrD), .irWrite(irWrite),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .resultSrc(resultSrc),
    .trap(trap), .retire(retire), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic step_t mk(input state_t st, input logic rdy);
    step_t s;
    s.st  = st;
    s.rdy = rdy;
    return s;
  endfunction

  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b0110011: return C_RTYPE;
      7'b0010011: return C_ITYPE;
      7'b1100011: return C_BRANCH;
      default:    return C_ILLEGAL;
    endcase
  endfunction

  // Expected control lines for one cycle in a given phase.
  function automatic exp_t expect_of(input state_t st, input logic rdy, input logic ret);
    exp_t e;
    e = '0;
    e.st = st;
    case (st)
      S_FETCH:     begin e.mem_req = 1'b1; e.src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
      S_DECODE:    begin e.src_a = 2'b10; e.src_b = 2'b10; end
      S_MEM_ADDR:  begin e.src_a = 2'b01; e.src_b = 2'b10; end
      S_MEM_READ:  begin e.mem_req = 1'b1; e.i_or_d = 1'b1; end
      S_MEM_WB:    begin e.reg_write = 1'b1; e.res_src = 2'b01; end
      S_MEM_WRITE: begin e.mem_req = 1'b1; e.mem_write = 1'b1; e.i_or_d = 1'b1; end
      S_EXEC_R:    begin e.src_a = 2'b01; e.alu_op = 2'b10; end
      S_EXEC_I:    begin e.src_a = 2'b01; e.src_b = 2'b10; e.alu_op = 2'b10; end
      S_ALU_WB:    begin e.reg_write = 1'b1; end
      S_BRANCH:    begin e.src_a = 2'b01; e.alu_op = 2'b01; e.pc_write_cond = 1'b1; e.res_src = 2'b10; end
      S_ILLEGAL:   begin e.trap = 1'b1; end
      default:     begin e = '0; end
    endcase
    e.retire = ret;
    return e;
  endfunction

  // One clock cycle of stimulus plus its expected response.
  task automatic cyc(input state_t st, input logic rdy, input logic [6:0] op,
                     input logic rst, input logic ret);
    @(posedge clk);
    #1;
    reset    = rst;
    memReady = rdy;
    opcode   = op;
    exp_q.push_back(expect_of(st, rdy, ret));
  endtask

  // Run one instruction: fw fetch waits, mw memory waits. abort_at >= 0 asserts
  // reset in that cycle of the instruction; illegal opcodes sit in ILLEGAL for
  // hold cycles and are then cleared by reset.
  task automatic issue(input logic [6:0] op, input int fw, input int mw,
                       input int abort_at, input int hold);
    step_t plan[$];
    int    cls;
    bit    done_ok;
    for (int i = 0; i < fw; i++) plan.push_back(mk(S_FETCH, 1'b0));
    plan.push_back(mk(S_FETCH, 1'b1));
    plan.push_back(mk(S_DECODE, rnd_bit()));
    cls = classify(op);
    case (cls)
      C_LOAD: begin
        plan.push_back(mk(S_MEM_ADDR, rnd_bit()));
        for (int i = 0; i < mw; i++) plan.push_back(mk(S_MEM_READ, 1'b0));
        plan.push_back(mk(S_MEM_READ, 1'b1));
        plan.push_back(mk(S_MEM_WB, rnd_bit()));
      end
      C_STORE: begin
        plan.push_back(mk(S_MEM_ADDR, rnd_bit()));
        for (int i = 0; i < mw; i++) plan.push_back(mk(S_MEM_WRITE, 1'b0));
        plan.push_back(mk(S_MEM_WRITE, 1'b1));
      end
      C_RTYPE: begin
        plan.push_back(mk(S_EXEC_R, rnd_bit()));
        plan.push_back(mk(S_ALU_WB, rnd_bit()));
      end
      C_ITYPE: begin
        plan.push_back(mk(S_EXEC_I, rnd_bit()));
        plan.push_back(mk(S_ALU_WB, rnd_bit()));
      end
      C_BRANCH: begin
        plan.push_back(mk(S_BRANCH, rnd_bit()));
      end
      default: begin
        for (int i = 0; i < hold; i++) plan.push_back(mk(S_ILLEGAL, rnd_bit()));
      end
    endcase
    done_ok = (cls != C_ILLEGAL) && (abort_at < 0 || abort_at >= plan.size());
    if (done_ok) lat_q.push_back(plan.size());
    for (int i = 0; i < plan.size(); i++) begin
      if (!done_ok && i == abort_at) break;
      cyc(plan[i].st, plan[i].rdy,
          (plan[i].st == S_FETCH) ? 7'($urandom) : op,
          1'b0, done_ok && (i == plan.size() - 1));
    end
    if (!done_ok) cyc(S_FETCH, 1'b0, 7'($urandom), 1'b1, 1'b0);
  endtask

  // Monitor: per-cycle output check and retire-latency scoreboard.
  initial begin
    exp_t e;
    exp_t act;
    int   lat_cnt;
    int   want;
    lat_cnt = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {state, memReq, memWrite, iOrD, irWrite, pcWrite, pcWriteCond,
               regWrite, aluSrcA, aluSrcB, aluOp, resultSrc, trap, retire};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t got=%h want=%h (state got %0d want %0d)",
                   $time, act, e, act.st, e.st);
        end
      end
      if (reset === 1'b1) begin
        lat_cnt = 0;
      end else begin
        lat_cnt++;
        if (retire === 1'b1) begin
          checks++;
          if (lat_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_retire t=%0t got=1 want=0", $time);
          end else begin
            want = lat_q.pop_front();
            if (lat_cnt != want) begin
              errors++;
              $display("FAIL retire_latency t=%0t got=%0d want=%0d", $time, lat_cnt, want);
            end
          end
          lat_cnt = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1);
  end

  // Stimulus: reset, directed scenarios, then randomized instruction stream.
  initial begin
    int r;
    logic [6:0] op;
    cyc(S_FETCH, 1'b0, 7'd0, 1'b1, 1'b0);
    cyc(S_FETCH, 1'b1, 7'd0, 1'b1, 1'b0);

    issue(7'b0110011, 0, 0, -1, 0);   // R-type, 4 cycles
    issue(7'b0000011, 0, 2, -1, 0);   // load, 2 wait cycles, 7 cycles
    issue(7'b0100011, 0, 0, -1, 0);   // store, 4 cycles
    issue(7'b1100011, 0, 0, -1, 0);   // branch, 3 cycles
    issue(7'b0010011, 1, 0, -1, 0);   // I-type with a fetch wait
    issue(7'b0100011, 2, 2, -1, 0);   // store with fetch and memory waits
    issue(7'b1111111, 0, 0, -1, 11);  // illegal, trap held then reset
    issue(7'b0000011, 0, 3, 4, 0);    // reset during stalled MEM_READ
    issue(7'b0110011, 0, 0, -1, 0);   // clean instruction after abort

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 15);
      if (r < 3)       op = 7'b0000011;
      else if (r < 6)  op = 7'b0100011;
      else if (r < 9)  op = 7'b0110011;
      else if (r < 12) op = 7'b0010011;
      else if (r < 14) op = 7'b1100011;
      else             op = 7'($urandom);
      issue(op, $urandom_range(0, 2), $urandom_range(0, 3),
            ($urandom_range(0, 11) == 0) ? $urandom_range(0, 6) : -1,
            $urandom_range(1, 4));
    end

    cyc(S_FETCH, 1'b0, 7'd0, 1'b1, 1'b0);
    cyc(S_FETCH, 1'b0, 7'd0, 1'b0, 1'b0);
    cyc(S_FETCH, 1'b0, 7'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (lat_q.size() != 0) begin
      errors++;
      $display("FAIL pending_retires got=%0d want=0", lat_q.size());
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_cycles got=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
